// File: rtl/cva6_hpdcache_req_arbiter.sv
// HPDcache request arbiter.
// Multiplexes NREQ core-side requesters onto the single HPDcache request port.
// Round-robin selection with a grant lock while the cache stalls, a one-cycle
// pipeline stage for the second-cycle qualifiers (abort/tag/pma) of virtually
// indexed requests, and sid-based response demultiplexing.
//
// Ports:
//   clk_i, rst_ni                         clock, asynchronous active-low reset
//   req_valid_i/req_ready_o/req_i         per-requester first-cycle handshake + payload
//   req_abort_i/req_tag_i/req_pma_i       per-requester second-cycle qualifiers
//   hpdcache_req_valid_o/_ready_i/_o      cache-side request handshake + payload
//   hpdcache_req_abort_o/_tag_o/_pma_o    cache-side second-cycle qualifiers
//   hpdcache_rsp_valid_i/hpdcache_rsp_i   cache response
//   rsp_valid_o/rsp_o                     per-requester response

package cva6_hpdcache_req_arbiter_pkg;
    typedef logic [3:0]  hpdcache_req_sid_t;
    typedef logic [15:0] hpdcache_tag_t;

    typedef struct packed {
        logic uncacheable;
        logic io;
    } hpdcache_pma_t;

    typedef struct packed {
        logic [11:0]       addr_offset;
        logic [31:0]       wdata;
        logic [3:0]        op;
        logic [3:0]        be;
        logic [2:0]        size;
        hpdcache_req_sid_t sid;
        logic [3:0]        tid;
        logic              need_rsp;
        logic              phys_indexed;
        logic [15:0]       addr_tag;
    } hpdcache_req_t;

    typedef struct packed {
        logic [31:0]       rdata;
        hpdcache_req_sid_t sid;
        logic [3:0]        tid;
        logic              error;
        logic              aborted;
    } hpdcache_rsp_t;
endpackage

module cva6_hpdcache_req_arbiter
    import cva6_hpdcache_req_arbiter_pkg::*;
#(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned SID_OFFSET = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  hpdcache_req_t         req_i [NREQ],
    input  logic [NREQ-1:0]       req_abort_i,
    input  hpdcache_tag_t         req_tag_i [NREQ],
    input  hpdcache_pma_t         req_pma_i [NREQ],

    output logic                  hpdcache_req_valid_o,
    input  logic                  hpdcache_req_ready_i,
    output hpdcache_req_t         hpdcache_req_o,
    output logic                  hpdcache_req_abort_o,
    output hpdcache_tag_t         hpdcache_req_tag_o,
    output hpdcache_pma_t         hpdcache_req_pma_o,

    input  logic                  hpdcache_rsp_valid_i,
    input  hpdcache_rsp_t         hpdcache_rsp_i,

    output logic [NREQ-1:0]       rsp_valid_o,
    output hpdcache_rsp_t         rsp_o [NREQ]
);

    localparam int unsigned IdxW = $clog2(NREQ);
    typedef logic [IdxW-1:0] idx_t;

    // ptr_q is the requester with the highest priority this cycle.
    idx_t ptr_q, ptr_d;
    logic lock_q, lock_d;
    idx_t lock_idx_q, lock_idx_d;
    logic pend_q, pend_d;
    idx_t pend_idx_q, pend_idx_d;

    idx_t sel;
    logic any_valid;
    logic accept;

    assign any_valid = |req_valid_i;
    assign accept    = any_valid & hpdcache_req_ready_i;

    // Selection never looks at hpdcache_req_ready_i, so valid_o has no
    // combinational dependency on ready.
    always_comb begin
        logic        found;
        int unsigned cand;
        sel   = ptr_q;
        found = 1'b0;
        cand  = 0;
        if (lock_q && req_valid_i[lock_idx_q]) begin
            sel = lock_idx_q;
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand = 32'(ptr_q) + k;
                if (cand >= NREQ) begin
                    cand = cand - NREQ;
                end
                if (!found && req_valid_i[cand[IdxW-1:0]]) begin
                    found = 1'b1;
                    sel   = cand[IdxW-1:0];
                end
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = any_valid & ~hpdcache_req_ready_i;
        lock_idx_d = sel;
        pend_d     = accept & ~req_i[sel].phys_indexed;
        pend_idx_d = sel;
        if (accept) begin
            if (32'(sel) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = sel + idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    // Request forwarding
    always_comb begin
        hpdcache_req_valid_o = any_valid;
        hpdcache_req_o       = req_i[sel];
        hpdcache_req_o.sid   = hpdcache_req_sid_t'(32'(sel) + SID_OFFSET);
        req_ready_o          = '0;
        req_ready_o[sel]     = any_valid & hpdcache_req_ready_i;
    end

    // Second-cycle qualifiers come from whoever was accepted last cycle
    always_comb begin
        hpdcache_req_abort_o = 1'b0;
        hpdcache_req_tag_o   = '0;
        hpdcache_req_pma_o   = '0;
        if (pend_q) begin
            hpdcache_req_abort_o = req_abort_i[pend_idx_q];
            hpdcache_req_tag_o   = req_tag_i[pend_idx_q];
            hpdcache_req_pma_o   = req_pma_i[pend_idx_q];
        end
    end

    // Response routing; an unmatched sid asserts no valid
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            rsp_valid_o[i] = hpdcache_rsp_valid_i &&
                             (hpdcache_rsp_i.sid == hpdcache_req_sid_t'(i + SID_OFFSET));
            rsp_o[i]       = hpdcache_rsp_i;
        end
    end

endmodule

// File: tb/tb_cva6_hpdcache_req_arbiter.sv
// Self-checking bench for cva6_hpdcache_req_arbiter: directed scenarios with
// literal expectations, then randomized traffic compared every cycle against a
// behavioural model of the arbitration rules.
module tb_cva6_hpdcache_req_arbiter;
    import cva6_hpdcache_req_arbiter_pkg::*;

    localparam int NREQ = 3;

    logic              clk_i;
    logic              rst_ni;
    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ-1:0]   req_ready_o;
    hpdcache_req_t     req_i [NREQ];
    logic [NREQ-1:0]   req_abort_i;
    hpdcache_tag_t     req_tag_i [NREQ];
    hpdcache_pma_t     req_pma_i [NREQ];
    logic              hpdcache_req_valid_o;
    logic              hpdcache_req_ready_i;
    hpdcache_req_t     hpdcache_req_o;
    logic              hpdcache_req_abort_o;
    hpdcache_tag_t     hpdcache_req_tag_o;
    hpdcache_pma_t     hpdcache_req_pma_o;
    logic              hpdcache_rsp_valid_i;
    hpdcache_rsp_t     hpdcache_rsp_i;
    logic [NREQ-1:0]   rsp_valid_o;
    hpdcache_rsp_t     rsp_o [NREQ];

    cva6_hpdcache_req_arbiter #(
        .NREQ       (NREQ),
        .SID_OFFSET (0)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .req_valid_i          (req_valid_i),
        .req_ready_o          (req_ready_o),
        .req_i                (req_i),
        .req_abort_i          (req_abort_i),
        .req_tag_i            (req_tag_i),
        .req_pma_i            (req_pma_i),
        .hpdcache_req_valid_o (hpdcache_req_valid_o),
        .hpdcache_req_ready_i (hpdcache_req_ready_i),
        .hpdcache_req_o       (hpdcache_req_o),
        .hpdcache_req_abort_o (hpdcache_req_abort_o),
        .hpdcache_req_tag_o   (hpdcache_req_tag_o),
        .hpdcache_req_pma_o   (hpdcache_req_pma_o),
        .hpdcache_rsp_valid_i (hpdcache_rsp_valid_i),
        .hpdcache_rsp_i       (hpdcache_rsp_i),
        .rsp_valid_o          (rsp_valid_o),
        .rsp_o                (rsp_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              m_last;      // last accepted requester
    bit              m_stall;     // previous cycle presented a request the cache refused
    int              m_stall_idx;
    bit              m_pend;      // previous cycle accepted a virtually indexed request
    int              m_pend_idx;
    logic [NREQ-1:0] m_acc_vec;

    function automatic int exp_grant();
        if (m_stall && req_valid_i[m_stall_idx]) return m_stall_idx;
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (req_valid_i[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_last    = NREQ - 1;
            m_stall   = 0;
            m_pend    = 0;
            m_acc_vec = '0;
        end else begin
            int g;
            bit acc;
            g         = exp_grant();
            acc       = (g >= 0) && hpdcache_req_ready_i;
            m_stall   = (g >= 0) && !hpdcache_req_ready_i;
            m_stall_idx = g;
            m_acc_vec = '0;
            m_pend    = 0;
            if (acc) begin
                m_last       = g;
                m_acc_vec[g] = 1'b1;
                m_pend       = !req_i[g].phys_indexed;
                m_pend_idx   = g;
            end
        end
    end

    // Compare process: every cycle, away from both edges.
    always @(negedge clk_i) begin
        #2;
        begin
            int              g;
            logic [NREQ-1:0] e_ready;
            logic [NREQ-1:0] e_rvalid;
            hpdcache_req_t   e_req;
            g = exp_grant();
            e_ready = '0;
            if (g >= 0) e_ready[g] = hpdcache_req_ready_i;
            chk("m_valid_o", hpdcache_req_valid_o, |req_valid_i);
            chk("m_ready_o", req_ready_o, e_ready);
            if (g >= 0) begin
                e_req     = req_i[g];
                e_req.sid = 4'(g);
                chk("m_req_o", hpdcache_req_o, e_req);
            end
            chk("m_abort_o", hpdcache_req_abort_o, m_pend ? req_abort_i[m_pend_idx] : 1'b0);
            chk("m_tag_o", hpdcache_req_tag_o, m_pend ? req_tag_i[m_pend_idx] : 16'h0);
            chk("m_pma_o", hpdcache_req_pma_o, m_pend ? req_pma_i[m_pend_idx] : 2'b0);
            for (int i = 0; i < NREQ; i++) begin
                e_rvalid[i] = hpdcache_rsp_valid_i && (hpdcache_rsp_i.sid == 4'(i));
                chk("m_rsp_o", rsp_o[i], hpdcache_rsp_i);
            end
            chk("m_rsp_valid_o", rsp_valid_o, e_rvalid);
        end
    end

    function automatic hpdcache_req_t rand_req();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[$bits(hpdcache_req_t)-1:0];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_ni               = 1'b0;
        req_valid_i          = '0;
        req_abort_i          = '0;
        hpdcache_req_ready_i = 1'b0;
        hpdcache_rsp_valid_i = 1'b0;
        hpdcache_rsp_i       = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_i[i]              = '0;
            req_i[i].phys_indexed = 1'b1;
            req_i[i].addr_tag     = 16'(i + 16'h10);
            req_tag_i[i]          = '0;
            req_pma_i[i]          = '0;
        end
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_abort", hpdcache_req_abort_o, 1'b0);
        chk("rst_tag", hpdcache_req_tag_o, 16'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Round-robin with everyone valid and the cache always ready
        @(negedge clk_i);
        req_valid_i          = 3'b111;
        hpdcache_req_ready_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr_grant", req_ready_o, 3'b001 << (c % 3));
            chk("rr_sid", hpdcache_req_o.sid, 4'(c % 3));
            @(negedge clk_i);
        end

        // Grant lock while stalled
        req_valid_i          = 3'b100;
        hpdcache_req_ready_i = 1'b0;
        #1;
        chk("lock_sid0", hpdcache_req_o.sid, 4'd2);
        chk("lock_ready0", req_ready_o, 3'b000);
        @(negedge clk_i);
        req_valid_i = 3'b101;
        #1;
        chk("lock_sid1", hpdcache_req_o.sid, 4'd2);
        @(negedge clk_i);
        #1;
        chk("lock_sid2", hpdcache_req_o.sid, 4'd2);
        @(negedge clk_i);
        hpdcache_req_ready_i = 1'b1;
        #1;
        chk("lock_accept", req_ready_o, 3'b100);
        @(negedge clk_i);
        req_valid_i = 3'b001;
        #1;
        chk("lock_then0", req_ready_o, 3'b001);
        @(negedge clk_i);

        // Virtually indexed load on port 1: qualifiers appear one cycle later only
        req_valid_i           = 3'b010;
        req_i[1].phys_indexed = 1'b0;
        req_tag_i[1]          = 16'hABC;
        req_abort_i           = 3'b010;
        #1;
        chk("ld_accept", req_ready_o, 3'b010);
        @(negedge clk_i);
        req_valid_i = 3'b000;
        #1;
        chk("ld_abort_n1", hpdcache_req_abort_o, 1'b1);
        chk("ld_tag_n1", hpdcache_req_tag_o, 16'hABC);
        @(negedge clk_i);
        #1;
        chk("ld_abort_n2", hpdcache_req_abort_o, 1'b0);
        chk("ld_tag_n2", hpdcache_req_tag_o, 16'h0);
        req_i[1].phys_indexed = 1'b1;

        // Physically indexed store on port 2: no qualifiers follow
        @(negedge clk_i);
        req_tag_i[2] = 16'h123;
        req_abort_i  = 3'b100;
        req_valid_i  = 3'b100;
        #1;
        chk("st_accept", req_ready_o, 3'b100);
        @(negedge clk_i);
        req_valid_i = 3'b000;
        #1;
        chk("st_abort", hpdcache_req_abort_o, 1'b0);
        chk("st_tag", hpdcache_req_tag_o, 16'h0);

        // Response routing
        @(negedge clk_i);
        hpdcache_rsp_valid_i = 1'b1;
        hpdcache_rsp_i       = '0;
        hpdcache_rsp_i.sid   = 4'd1;
        hpdcache_rsp_i.rdata = 32'hDEAD_BEEF;
        #1;
        chk("rsp_sid1", rsp_valid_o, 3'b010);
        chk("rsp_data1", rsp_o[1].rdata, 32'hDEAD_BEEF);
        @(negedge clk_i);
        hpdcache_rsp_i.sid = 4'd7;
        #1;
        chk("rsp_sid7", rsp_valid_o, 3'b000);
        @(negedge clk_i);
        hpdcache_rsp_valid_i = 1'b0;

        // Reset during a locked, stalled grant to port 2
        req_valid_i          = 3'b100;
        hpdcache_req_ready_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni      = 1'b0;
        req_valid_i = 3'b111;
        #1;
        chk("rst_lock_abort", hpdcache_req_abort_o, 1'b0);
        @(negedge clk_i);
        rst_ni               = 1'b1;
        hpdcache_req_ready_i = 1'b1;
        #1;
        chk("rst_lock_p0", req_ready_o, 3'b001);
        @(negedge clk_i);

        // Reset between a virtually indexed acceptance and its second cycle
        req_valid_i           = 3'b010;
        req_i[1].phys_indexed = 1'b0;
        req_abort_i           = 3'b010;
        #1;
        chk("rst_pend_acc", req_ready_o, 3'b010);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rst_pend_abort", hpdcache_req_abort_o, 1'b0);
        chk("rst_pend_tag", hpdcache_req_tag_o, 16'h0);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        req_valid_i = 3'b000;
        #1;
        chk("rst_pend_after", hpdcache_req_abort_o, 1'b0);
        req_i[1].phys_indexed = 1'b1;

        // Randomized traffic; requesters hold valid until accepted
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid_i[i] || m_acc_vec[i]) begin
                    req_valid_i[i] = ($urandom_range(0, 2) != 0);
                    req_i[i]       = rand_req();
                end
                req_abort_i[i] = 1'($urandom());
                req_tag_i[i]   = 16'($urandom());
                req_pma_i[i]   = 2'($urandom());
            end
            hpdcache_req_ready_i = ($urandom_range(0, 3) != 0);
            hpdcache_rsp_valid_i = 1'($urandom());
            hpdcache_rsp_i       = hpdcache_rsp_t'(42'({$urandom(), $urandom()}));
            hpdcache_rsp_i.sid   = 4'($urandom_range(0, 4) == 0 ? $urandom_range(0, 15)
                                                                 : $urandom_range(0, 2));
        end
        @(negedge clk_i);
        #3;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
